// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: shared AHB transfer/response encodings, arbiter FSM states and master index width
package ahb_arb_pkg;
    localparam int MIDX_W = 4;
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_t;
    typedef enum logic [1:0] {OKAY = 2'b00, ERROR = 2'b01, RETRY = 2'b10, SPLIT = 2'b11} hresp_t;
    typedef enum logic [1:0] {PARK = 2'b00, GRANT = 2'b01, LOCK = 2'b10} arb_state_t;
    function automatic logic beat_active(input logic [1:0] trans);
        return (htrans_t'(trans) == NONSEQ) || (htrans_t'(trans) == SEQ);
    endfunction
endpackage

// File: rtl/ahb_rr_pick.sv
// ahb_rr_pick: combinational rotating priority encoder
//   i_req    request vector
//   i_ptr    last winner; search starts at i_ptr+1 and wraps at N-1 -> 0
//   o_onehot one-hot winner (zero when no request)
//   o_idx    winner index
//   o_any    at least one request set
module ahb_rr_pick import ahb_arb_pkg::*; #(
    parameter int N = 16
) (
    input  logic [N-1:0]      i_req,
    input  logic [MIDX_W-1:0] i_ptr,
    output logic [N-1:0]      o_onehot,
    output logic [MIDX_W-1:0] o_idx,
    output logic              o_any
);
    logic [MIDX_W:0]   w_sum;
    logic [MIDX_W-1:0] w_j;
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_sum    = '0;
        w_j      = '0;
        // k runs 1..N so the previous winner is considered last
        for (int k = 1; k <= N; k++) begin
            w_sum = {1'b0, i_ptr} + (MIDX_W+1)'(k);
            w_j   = (w_sum >= (MIDX_W+1)'(N)) ? MIDX_W'(w_sum - (MIDX_W+1)'(N)) : MIDX_W'(w_sum);
            if (!o_any && i_req[w_j]) begin
                o_any         = 1'b1;
                o_idx         = w_j;
                o_onehot[w_j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: round-robin AHB arbiter with lock, SPLIT masking, tenure cap and parked default master
//   HCLK      bus clock, rising edge
//   HRESET    synchronous active-high reset
//   HBUSREQx  per-master bus request
//   HLOCKx    per-master lock request
//   HSPLIT    per-master un-split strobe from slaves
//   HREADY    transfer complete / arbitration point
//   HTRANS    current transfer type
//   HRESP     current slave response
//   HGRANTx   one-hot grant
//   HMASTER   owner of the current address phase
//   HMASTLOCK current address phase is locked
// Optional: define AHB_RR_ARB_SVA_EN to embed protocol assertions.
module ahb_rr_arbiter import ahb_arb_pkg::*; #(
    parameter int NUM_MASTERS    = 16,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_TENURE     = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQx,
    input  logic [NUM_MASTERS-1:0] HLOCKx,
    input  logic [NUM_MASTERS-1:0] HSPLIT,
    input  logic                   HREADY,
    input  logic [1:0]             HTRANS,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HGRANTx,
    output logic [MIDX_W-1:0]      HMASTER,
    output logic                   HMASTLOCK
);
    localparam int TEN_W = 8;
    localparam logic [MIDX_W-1:0]      DEF_IDX    = MIDX_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_t             r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
    // the round-robin pointer always equals the current owner index
    logic [MIDX_W-1:0]      r_rr_ptr, w_ptr_nxt;
    logic [NUM_MASTERS-1:0] r_split_mask;
    logic [TEN_W-1:0]       r_tenure, w_tenure_nxt;
    logic [MIDX_W-1:0]      r_hmaster;
    logic                   r_hmastlock;

    logic [NUM_MASTERS-1:0] w_elig, w_win_onehot, w_split_set;
    logic [MIDX_W-1:0]      w_win_idx;
    logic                   w_win_any, w_owner_elig, w_others, w_tenure_max, w_lock_req;
    logic                   w_rearb, w_change;

    assign w_elig       = HBUSREQx & ~r_split_mask;
    assign w_owner_elig = w_elig[r_rr_ptr];
    assign w_others     = |(w_elig & ~r_grant);
    assign w_tenure_max = (r_tenure == TEN_W'(MAX_TENURE));
    assign w_lock_req   = HLOCKx[r_rr_ptr] & HBUSREQx[r_rr_ptr];
    // SPLIT is signalled in the first (wait) cycle of the two-cycle response
    assign w_split_set  = (hresp_t'(HRESP) == SPLIT && !HREADY) ? (NUM_MASTERS'(1) << r_hmaster) : '0;

    ahb_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .i_req    (w_elig),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_win_onehot),
        .o_idx    (w_win_idx),
        .o_any    (w_win_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_rr_ptr;
        w_rearb     = 1'b0;
        if (!w_win_any) begin
            w_state_nxt = PARK;
            w_grant_nxt = DEF_ONEHOT;
            w_ptr_nxt   = DEF_IDX;
        end else begin
            case (r_state)
                PARK:    w_rearb = 1'b1;
                // losing eligibility (dropped request or split) outranks lock; lock outranks tenure
                GRANT: begin
                    if (!w_owner_elig)
                        w_rearb = 1'b1;
                    else if (w_lock_req)
                        w_state_nxt = LOCK;
                    else if (w_tenure_max && w_others)
                        w_rearb = 1'b1;
                end
                LOCK:    w_rearb = !w_owner_elig || !HLOCKx[r_rr_ptr];
                default: w_rearb = 1'b1;
            endcase
            if (w_rearb) begin
                w_state_nxt = GRANT;
                w_grant_nxt = w_win_onehot;
                w_ptr_nxt   = w_win_idx;
            end
        end
    end

    assign w_change     = (w_grant_nxt != r_grant);
    assign w_tenure_nxt = w_change ? '0 :
                          (beat_active(HTRANS) && !w_tenure_max) ? r_tenure + 1'b1 : r_tenure;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state      <= PARK;
            r_grant      <= DEF_ONEHOT;
            r_rr_ptr     <= DEF_IDX;
            r_split_mask <= '0;
            r_tenure     <= '0;
            r_hmaster    <= DEF_IDX;
            r_hmastlock  <= 1'b0;
        end else begin
            // a new split outranks a simultaneous un-split of the same master
            r_split_mask <= (r_split_mask & ~HSPLIT) | w_split_set;
            if (HREADY) begin
                r_state     <= w_state_nxt;
                r_grant     <= w_grant_nxt;
                r_rr_ptr    <= w_ptr_nxt;
                r_tenure    <= w_tenure_nxt;
                r_hmaster   <= r_rr_ptr;
                r_hmastlock <= HLOCKx[r_rr_ptr];
            end
        end
    end

    assign HGRANTx   = r_grant;
    assign HMASTER   = r_hmaster;
    assign HMASTLOCK = r_hmastlock;

`ifdef AHB_RR_ARB_SVA_EN
    a_onehot: assert property (@(posedge HCLK) $onehot(HGRANTx))
        else $error("grant not one-hot, owner %0d", r_rr_ptr);
    a_stable: assert property (@(posedge HCLK) (!HREADY && !HRESET) |=> $stable(HGRANTx))
        else $error("grant changed during wait state, owner %0d", r_rr_ptr);
    a_split: assert property (@(posedge HCLK) disable iff (HRESET)
        HREADY |=> (r_state == PARK) || ((HGRANTx & r_split_mask) == '0))
        else $error("split master %0d granted", r_rr_ptr);
    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_live
        a_live: assert property (@(posedge HCLK) disable iff (HRESET || (|HLOCKx) || (|r_split_mask))
            HBUSREQx[g] |-> ##[0:NUM_MASTERS*MAX_TENURE] HGRANTx[g])
            else $error("master %0d not granted in time", g);
    end
`endif
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb_ahb_rr_arbiter: directed self-checking bench for ahb_rr_arbiter
module tb_ahb_rr_arbiter;
    import ahb_arb_pkg::*;
    localparam int N = 16;

    logic         HCLK = 1'b0;
    logic         HRESET = 1'b1;
    logic         HREADY = 1'b1;
    logic [N-1:0] HBUSREQx = '0;
    logic [N-1:0] HLOCKx = '0;
    logic [N-1:0] HSPLIT = '0;
    logic [1:0]   HTRANS = 2'b00;
    logic [1:0]   HRESP = 2'b00;
    logic [N-1:0] HGRANTx;
    logic [3:0]   HMASTER;
    logic         HMASTLOCK;
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_rr_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0), .MAX_TENURE(8)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQx  (HBUSREQx),
        .HLOCKx    (HLOCKx),
        .HSPLIT    (HSPLIT),
        .HREADY    (HREADY),
        .HTRANS    (HTRANS),
        .HRESP     (HRESP),
        .HGRANTx   (HGRANTx),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        HRESET   = 1'b1;
        HBUSREQx = '0;
        HLOCKx   = '0;
        HSPLIT   = '0;
        HREADY   = 1'b1;
        HTRANS   = IDLE;
        HRESP    = OKAY;
        tick();
        HRESET   = 1'b0;
    endtask

    initial begin
        tick(2);
        HRESET = 1'b0;
        chk("reset_grant", HGRANTx, 32'h0001);
        chk("reset_hmaster", HMASTER, 32'h0);
        chk("reset_hmastlock", HMASTLOCK, 32'h0);
        chk("reset_state", dut.r_state, PARK);
        tick();
        chk("park_idle_grant", HGRANTx, 32'h0001);
        chk("park_idle_state", dut.r_state, PARK);

        HBUSREQx = 16'h0016;
        HTRANS   = NONSEQ;
        tick();
        chk("rr_first_m1", HGRANTx, 32'h0002);
        chk("rr_first_tenure", dut.r_tenure, 32'h0);
        tick();
        chk("rr_hmaster_m1", HMASTER, 32'h1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("rr_hold_m1", HGRANTx, 32'h0002);
        end
        chk("rr_tenure_sat", dut.r_tenure, 32'h8);
        tick();
        chk("rr_switch_m2", HGRANTx, 32'h0004);
        chk("rr_hmaster_lag", HMASTER, 32'h1);
        chk("rr_tenure_clr", dut.r_tenure, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_hold_m2", HGRANTx, 32'h0004);
        end
        tick();
        chk("rr_switch_m4", HGRANTx, 32'h0010);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_hold_m4", HGRANTx, 32'h0010);
        end
        tick();
        chk("rr_wrap_m1", HGRANTx, 32'h0002);

        do_reset();
        HBUSREQx = 16'h0028;
        HLOCKx   = 16'h0008;
        HTRANS   = NONSEQ;
        tick();
        chk("lock_grant_m3", HGRANTx, 32'h0008);
        chk("lock_mastlock_lag", HMASTLOCK, 32'h0);
        tick();
        chk("lock_mastlock", HMASTLOCK, 32'h1);
        chk("lock_hmaster", HMASTER, 32'h3);
        chk("lock_state", dut.r_state, LOCK);
        for (int i = 0; i < 18; i++) begin
            tick();
            chk("lock_hold_m3", HGRANTx, 32'h0008);
        end
        HLOCKx = '0;
        tick();
        chk("lock_release_m5", HGRANTx, 32'h0020);
        chk("lock_release_state", dut.r_state, GRANT);
        chk("lock_release_mastlock", HMASTLOCK, 32'h0);

        do_reset();
        HBUSREQx = 16'h0044;
        HTRANS   = NONSEQ;
        tick();
        chk("split_grant_m2", HGRANTx, 32'h0004);
        tick();
        chk("split_hmaster_m2", HMASTER, 32'h2);
        HREADY = 1'b0;
        HRESP  = SPLIT;
        tick();
        chk("split_wait_grant", HGRANTx, 32'h0004);
        chk("split_mask_set", dut.r_split_mask, 32'h0004);
        HREADY = 1'b1;
        tick();
        chk("split_move_m6", HGRANTx, 32'h0040);
        HRESP = OKAY;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("split_excl_m2", HGRANTx, 32'h0040);
        end
        HSPLIT = 16'h0004;
        tick();
        chk("unsplit_mask_clr", dut.r_split_mask, 32'h0);
        chk("unsplit_same_edge", HGRANTx, 32'h0040);
        HSPLIT = '0;
        tick();
        chk("unsplit_regrant_m2", HGRANTx, 32'h0004);

        do_reset();
        HBUSREQx = 16'h0010;
        HTRANS   = NONSEQ;
        tick();
        chk("wait_grant_m4", HGRANTx, 32'h0010);
        tick();
        chk("wait_hmaster_m4", HMASTER, 32'h4);
        HREADY   = 1'b0;
        HBUSREQx = 16'h0080;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wait_grant_hold", HGRANTx, 32'h0010);
            chk("wait_hmaster_hold", HMASTER, 32'h4);
        end
        HREADY = 1'b1;
        tick();
        chk("wait_grant_m7", HGRANTx, 32'h0080);
        chk("wait_hmaster_lag", HMASTER, 32'h4);
        tick();
        chk("wait_hmaster_m7", HMASTER, 32'h7);

        do_reset();
        HBUSREQx = 16'h0010;
        HTRANS   = SEQ;
        tick();
        chk("mrst_grant_m4", HGRANTx, 32'h0010);
        tick(2);
        chk("mrst_tenure_pre", dut.r_tenure, 32'h2);
        HREADY = 1'b0;
        HRESP  = SPLIT;
        tick();
        chk("mrst_mask_pre", dut.r_split_mask, 32'h0010);
        HRESET = 1'b1;
        HREADY = 1'b1;
        HRESP  = OKAY;
        tick();
        chk("mrst_grant", HGRANTx, 32'h0001);
        chk("mrst_mask", dut.r_split_mask, 32'h0);
        chk("mrst_tenure", dut.r_tenure, 32'h0);
        chk("mrst_hmaster", HMASTER, 32'h0);
        chk("mrst_hmastlock", HMASTLOCK, 32'h0);
        chk("mrst_state", dut.r_state, PARK);
        HRESET   = 1'b0;
        HBUSREQx = '0;
        tick();
        chk("mrst_park", HGRANTx, 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
